// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive sequencer.
//   RX_Sequencer_state_type : receive sequencer FSM states
//   CNT_W                   : width of the saturating error counters
//   TIMEOUT_CYCLES_DEFAULT  : default idle cycles before a character timeout
//   sat_inc()               : saturating increment for the error counters
package uart_pkg;

    typedef enum logic [1:0] {
        S_RXS_IDLE,
        S_RXS_WAIT,
        S_RXS_CAPTURE,
        S_RXS_SETTLE
    } RX_Sequencer_state_type;

    localparam int unsigned CNT_W = 8;

    localparam logic [15:0] TIMEOUT_CYCLES_DEFAULT = 16'd40000;

    // Increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/uart_rx_sequencer_if.sv
// Byte stream from the receive sequencer to the register front end.
//   Rd_valid : FIFO head holds a byte
//   Rd_data  : FIFO head byte (first-word fall-through)
//   Rd_ready : consumer takes the head when Rd_valid & Rd_ready
// master = sequencer side, slave = consumer side.
interface uart_rx_sequencer_if;

    logic       Rd_valid;
    logic [7:0] Rd_data;
    logic       Rd_ready;

    modport master (
        output Rd_valid,
        output Rd_data,
        input  Rd_ready
    );

    modport slave (
        input  Rd_valid,
        input  Rd_data,
        output Rd_ready
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO with first-word fall-through head.
//   clk, Resetn   : clock, asynchronous active-low reset
//   push/push_data: write request and byte
//   pop           : read request (ignored while empty)
//   flush         : empty the FIFO; a same-cycle push or pop is discarded
//   level         : occupancy 0..FIFO_DEPTH
//   valid         : level != 0
//   head_data_c   : head byte, 0 while empty
//   push_acc_c    : push request was accepted
//   drop_c        : push request dropped because full with no pop
module uart_rx_fifo #(
    parameter  int unsigned FIFO_DEPTH = 16,
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1,
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             Resetn,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [LVL_W-1:0] level,
    output logic             valid,
    output logic [7:0]       head_data_c,
    output logic             push_acc_c,
    output logic             drop_c
);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_d;
    logic             pop_ok;
    logic             full;

    // Accept/drop decisions; a pop frees the slot a same-cycle push needs.
    always_comb begin
        pop_ok     = pop & valid;
        full       = (level == LVL_W'(FIFO_DEPTH));
        push_acc_c = push & (~full | pop_ok);
        drop_c     = push & full & ~pop_ok & ~flush;
        level_d    = level;
        case ({push_acc_c, pop_ok})
            2'b10:   level_d = level + LVL_W'(1);
            2'b01:   level_d = level - LVL_W'(1);
            default: level_d = level;
        endcase
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            valid  <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            valid  <= 1'b0;
        end else begin
            if (push_acc_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)     rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level_d;
            valid <= (level_d != '0);
        end
    end

    // Storage needs no reset: the head is masked until a byte is written.
    always_ff @(posedge clk) begin
        if (push_acc_c && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data_c = valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: enables the receive controller, unloads each
// completed byte into a local FIFO, and presents it as a valid/ready stream.
// Keeps saturating overrun/frame-error counters, a sticky FIFO-overflow flag
// and a level/overflow interrupt.
//   clk, Resetn            : clock, asynchronous active-low reset
//   Rx_enable_cfg_i        : software receive enable (Rx_enable_o is it, delayed)
//   Rx_data_i/Rx_empty_i   : byte and Empty from the receive controller
//   Rx_overrun_i           : overrun status (counted on rising edge)
//   Rx_frame_error_i       : frame-error status (counted on rising edge)
//   Unload_data_o          : one-cycle unload strobe to the receive controller
//   rd                     : byte stream to the register front end
//   Flush_i                : discard FIFO contents
//   Clear_status_i         : clear counters, overflow and timeout flags
//   Threshold_i/Level_o    : interrupt level threshold (0 = off), occupancy
//   Overrun_count_o, Frame_err_count_o, Fifo_overflow_o, Timeout_o, Irq_o
// Optional: define UART_RX_SEQ_TIMEOUT_EN to enable the character timeout.
module uart_rx_sequencer
    import uart_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH     = 16,
`ifdef UART_RX_SEQ_TIMEOUT_EN
    parameter  logic [15:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
`endif
    localparam int unsigned LVL_W          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  Resetn,
    input  logic                  Rx_enable_cfg_i,
    output logic                  Rx_enable_o,
    input  logic [7:0]            Rx_data_i,
    input  logic                  Rx_empty_i,
    input  logic                  Rx_overrun_i,
    input  logic                  Rx_frame_error_i,
    output logic                  Unload_data_o,
    uart_rx_sequencer_if.master   rd,
    input  logic                  Flush_i,
    input  logic                  Clear_status_i,
    input  logic [LVL_W-1:0]      Threshold_i,
    output logic [LVL_W-1:0]      Level_o,
    output logic [CNT_W-1:0]      Overrun_count_o,
    output logic [CNT_W-1:0]      Frame_err_count_o,
    output logic                  Fifo_overflow_o,
    output logic                  Timeout_o,
    output logic                  Irq_o
);

    RX_Sequencer_state_type state_q;
    RX_Sequencer_state_type state_d;
    logic                   unload_d;
    logic                   push;
    logic                   pop;
    logic                   push_acc;
    logic                   drop;
    logic                   ov_q;
    logic                   fe_q;

    // Enable follows software config one cycle late.
    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) Rx_enable_o <= 1'b0;
        else         Rx_enable_o <= Rx_enable_cfg_i;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q       <= S_RXS_IDLE;
            Unload_data_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            Unload_data_o <= unload_d;
        end
    end

    // Next state; SETTLE gives Empty a cycle to rise after the unload.
    always_comb begin
        state_d  = state_q;
        unload_d = 1'b0;
        case (state_q)
            S_RXS_IDLE: begin
                if (Rx_enable_o) state_d = S_RXS_WAIT;
            end
            S_RXS_WAIT: begin
                if (!Rx_enable_o)     state_d = S_RXS_IDLE;
                else if (!Rx_empty_i) state_d = S_RXS_CAPTURE;
            end
            S_RXS_CAPTURE: state_d = S_RXS_SETTLE;
            S_RXS_SETTLE:  state_d = S_RXS_WAIT;
            default:       state_d = S_RXS_IDLE;
        endcase
        unload_d = (state_d == S_RXS_CAPTURE);
    end

    assign push = (state_q == S_RXS_CAPTURE);
    assign pop  = rd.Rd_valid & rd.Rd_ready;

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .Resetn      (Resetn),
        .push        (push),
        .push_data   (Rx_data_i),
        .pop         (pop),
        .flush       (Flush_i),
        .level       (Level_o),
        .valid       (rd.Rd_valid),
        .head_data_c (rd.Rd_data),
        .push_acc_c  (push_acc),
        .drop_c      (drop)
    );

    // Edge-detected saturating error counters; clear beats a same-cycle edge.
    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            ov_q              <= 1'b0;
            fe_q              <= 1'b0;
            Overrun_count_o   <= '0;
            Frame_err_count_o <= '0;
        end else begin
            ov_q <= Rx_overrun_i;
            fe_q <= Rx_frame_error_i;
            if (Clear_status_i) begin
                Overrun_count_o   <= '0;
                Frame_err_count_o <= '0;
            end else begin
                if (Rx_overrun_i && !ov_q)
                    Overrun_count_o <= sat_inc(Overrun_count_o);
                if (Rx_frame_error_i && !fe_q)
                    Frame_err_count_o <= sat_inc(Frame_err_count_o);
            end
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn)             Fifo_overflow_o <= 1'b0;
        else if (Clear_status_i) Fifo_overflow_o <= 1'b0;
        else if (drop)           Fifo_overflow_o <= 1'b1;
    end

`ifdef UART_RX_SEQ_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    // Idle counter restarts on any FIFO activity and holds at the limit.
    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            tmo_cnt_q <= '0;
            Timeout_o <= 1'b0;
        end else begin
            if (push_acc || pop || Flush_i)
                tmo_cnt_q <= '0;
            else if (Level_o != '0 && tmo_cnt_q != (TIMEOUT_CYCLES - 16'd1))
                tmo_cnt_q <= tmo_cnt_q + 16'd1;

            if (Clear_status_i || Level_o == '0)
                Timeout_o <= 1'b0;
            else if (tmo_cnt_q == (TIMEOUT_CYCLES - 16'd1))
                Timeout_o <= 1'b1;
        end
    end
`else
    logic unused_push_acc;
    assign unused_push_acc = push_acc;
    assign Timeout_o       = 1'b0;
`endif

    // Interrupt from current level, overflow and timeout.
    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) Irq_o <= 1'b0;
        else         Irq_o <= ((Threshold_i != '0) && (Level_o >= Threshold_i))
                              | Fifo_overflow_o | Timeout_o;
    end

endmodule

// File: tb/tb_uart_rx_sequencer.sv
module tb_uart_rx_sequencer;

    localparam int DEPTH = 16;
    localparam int LVL_W = 5;
`ifdef UART_RX_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TMO = 100;

    logic             clk = 1'b0;
    logic             Resetn;
    logic             Rx_enable_cfg_i;
    logic             Rx_enable_o;
    logic [7:0]       Rx_data_i;
    logic             Rx_empty_i;
    logic             Rx_overrun_i;
    logic             Rx_frame_error_i;
    logic             Unload_data_o;
    logic             Flush_i;
    logic             Clear_status_i;
    logic [LVL_W-1:0] Threshold_i;
    logic [LVL_W-1:0] Level_o;
    logic [7:0]       Overrun_count_o;
    logic [7:0]       Frame_err_count_o;
    logic             Fifo_overflow_o;
    logic             Timeout_o;
    logic             Irq_o;

    uart_rx_sequencer_if rd_if ();

    uart_rx_sequencer #(
        .FIFO_DEPTH (DEPTH)
`ifdef UART_RX_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYCLES (16'(TMO))
`endif
    ) dut (
        .clk               (clk),
        .Resetn            (Resetn),
        .Rx_enable_cfg_i   (Rx_enable_cfg_i),
        .Rx_enable_o       (Rx_enable_o),
        .Rx_data_i         (Rx_data_i),
        .Rx_empty_i        (Rx_empty_i),
        .Rx_overrun_i      (Rx_overrun_i),
        .Rx_frame_error_i  (Rx_frame_error_i),
        .Unload_data_o     (Unload_data_o),
        .rd                (rd_if),
        .Flush_i           (Flush_i),
        .Clear_status_i    (Clear_status_i),
        .Threshold_i       (Threshold_i),
        .Level_o           (Level_o),
        .Overrun_count_o   (Overrun_count_o),
        .Frame_err_count_o (Frame_err_count_o),
        .Fifo_overflow_o   (Fifo_overflow_o),
        .Timeout_o         (Timeout_o),
        .Irq_o             (Irq_o)
    );

    always #5 clk = ~clk;

    // Reference model state: FIFO as a queue plus flags and counters.
    logic [7:0] q[$];
    bit         m_ovf, m_irq, m_tmo, m_ov_prev, m_fe_prev;
    int         m_ovc, m_fec, m_idle, unload_cnt;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model from pre-edge inputs, emulate the receiver.
    task automatic tick();
        bit u, rdy, fl, clr, ov, fe, pop, pushed, drop;
        int lvl, thr;
        logic [7:0] d;
        u = Unload_data_o; rdy = rd_if.Rd_ready; fl = Flush_i; clr = Clear_status_i;
        ov = Rx_overrun_i; fe = Rx_frame_error_i; thr = int'(Threshold_i); d = Rx_data_i;
        @(posedge clk);
        #1;
        lvl    = q.size();
        m_irq  = ((thr != 0) && (lvl >= thr)) || m_ovf || m_tmo;
        pop    = (lvl != 0) && rdy;
        pushed = 1'b0;
        drop   = 1'b0;
        if (u) unload_cnt++;
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (u) begin
                if (q.size() < DEPTH) begin q.push_back(d); pushed = 1'b1; end
                else drop = 1'b1;
            end
        end
        if (clr) m_ovf = 1'b0; else if (drop) m_ovf = 1'b1;
        if (clr) m_ovc = 0; else if (ov && !m_ov_prev && m_ovc < 255) m_ovc++;
        if (clr) m_fec = 0; else if (fe && !m_fe_prev && m_fec < 255) m_fec++;
        m_ov_prev = ov;
        m_fe_prev = fe;
        if (TMO_EN) begin
            if (clr || lvl == 0) m_tmo = 1'b0;
            else if (m_idle == TMO - 1) m_tmo = 1'b1;
            if (pushed || pop || fl) m_idle = 0;
            else if (lvl != 0 && m_idle != TMO - 1) m_idle++;
        end
        if (u) Rx_empty_i = 1'b1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"}, 32'(Level_o), 32'(q.size()));
        chk({tag, ".valid"}, 32'(rd_if.Rd_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk({tag, ".data"}, 32'(rd_if.Rd_data), 32'(q[0]));
        chk({tag, ".ovf"}, 32'(Fifo_overflow_o), 32'(m_ovf));
        chk({tag, ".irq"}, 32'(Irq_o), 32'(m_irq));
        chk({tag, ".tmo"}, 32'(Timeout_o), 32'(m_tmo));
        chk({tag, ".ovc"}, 32'(Overrun_count_o), 32'(m_ovc));
        chk({tag, ".fec"}, 32'(Frame_err_count_o), 32'(m_fec));
    endtask

    // Present a byte and wait (bounded) for the sequencer to unload it.
    task automatic send_byte(input logic [7:0] b, output int cyc);
        Rx_data_i  = b;
        Rx_empty_i = 1'b0;
        cyc = 0;
        while (!Rx_empty_i && cyc < 12) begin tick(); cyc++; end
        chk("unload_seen", 32'(Rx_empty_i), 32'd1);
    endtask

    task automatic pop_byte(input string tag, input logic [7:0] exp);
        chk(tag, 32'(rd_if.Rd_data), 32'(exp));
        rd_if.Rd_ready = 1'b1;
        tick();
        rd_if.Rd_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        Clear_status_i = 1'b1; tick(); Clear_status_i = 1'b0;
    endtask

    task automatic pulse_flush();
        Flush_i = 1'b1; tick(); Flush_i = 1'b0;
    endtask

    initial begin
        int cyc, n, u0;
        Resetn = 1'b0; Rx_enable_cfg_i = 1'b0; Rx_data_i = 8'h00; Rx_empty_i = 1'b1;
        Rx_overrun_i = 1'b0; Rx_frame_error_i = 1'b0; Flush_i = 1'b0;
        Clear_status_i = 1'b0; Threshold_i = '0; rd_if.Rd_ready = 1'b0;
        unload_cnt = 0; m_ovc = 0; m_fec = 0; m_idle = 0;
        m_ovf = 0; m_irq = 0; m_tmo = 0; m_ov_prev = 0; m_fe_prev = 0;

        // Reset values
        #22;
        chk("rst.enable", 32'(Rx_enable_o), 32'd0);
        chk("rst.unload", 32'(Unload_data_o), 32'd0);
        chk("rst.data",   32'(rd_if.Rd_data), 32'd0);
        check_all("rst");
        @(negedge clk);
        Resetn = 1'b1;

        // Single byte 0x55
        Rx_enable_cfg_i = 1'b1;
        tick(); tick();
        chk("t1.enable", 32'(Rx_enable_o), 32'd1);
        send_byte(8'h55, cyc);
        chk("t1.latency", 32'(cyc), 32'd2);
        chk("t1.unloads", 32'(unload_cnt), 32'd1);
        chk("t1.level", 32'(Level_o), 32'd1);
        chk("t1.data", 32'(rd_if.Rd_data), 32'h55);
        tick();
        check_all("t1");
        pop_byte("t1.pop", 8'h55);
        check_all("t1p");

        // Fill 16, 17th dropped with overflow
        for (int i = 0; i < 16; i++) send_byte(8'(i), cyc);
        send_byte(8'hAA, cyc);
        tick(); tick();
        chk("t2.level", 32'(Level_o), 32'd16);
        chk("t2.ovf", 32'(Fifo_overflow_o), 32'd1);
        chk("t2.irq", 32'(Irq_o), 32'd1);
        check_all("t2");
        for (int i = 0; i < 16; i++) pop_byte("t2.pop", 8'(i));
        check_all("t2e");

        // Full FIFO: push coinciding with a pop is accepted
        pulse_clear();
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), cyc);
        tick();
        Rx_data_i = 8'hBB; Rx_empty_i = 1'b0;
        n = 0;
        while (Unload_data_o !== 1'b1 && n < 12) begin tick(); n++; end
        chk("t3.unload", 32'(Unload_data_o), 32'd1);
        rd_if.Rd_ready = 1'b1; tick(); rd_if.Rd_ready = 1'b0;
        chk("t3.level", 32'(Level_o), 32'd16);
        check_all("t3");
        for (int i = 1; i < 16; i++) pop_byte("t3.pop", 8'(8'h20 + i));
        pop_byte("t3.last", 8'hBB);
        check_all("t3e");

        // Level threshold interrupt
        pulse_clear();
        Threshold_i = LVL_W'(4);
        for (int i = 0; i < 3; i++) send_byte(8'(8'h40 + i), cyc);
        tick(); tick();
        chk("t4.irq3", 32'(Irq_o), 32'd0);
        send_byte(8'h43, cyc);
        chk("t4.lvl4", 32'(Level_o), 32'd4);
        chk("t4.irq_pre", 32'(Irq_o), 32'd0);
        tick();
        chk("t4.irq_on", 32'(Irq_o), 32'd1);
        pop_byte("t4.pop", 8'h40);
        tick();
        chk("t4.irq_off", 32'(Irq_o), 32'd0);
        check_all("t4");
        Threshold_i = '0;
        rd_if.Rd_ready = 1'b1;
        pulse_flush();
        rd_if.Rd_ready = 1'b0;
        chk("t4.flush", 32'(Level_o), 32'd0);
        check_all("t4f");

        // Error counters: saturation and clear priority
        for (int i = 0; i < 300; i++) begin
            Rx_frame_error_i = 1'b1; tick(); Rx_frame_error_i = 1'b0; tick();
        end
        chk("t5.fec_sat", 32'(Frame_err_count_o), 32'hFF);
        for (int i = 0; i < 5; i++) begin
            Rx_overrun_i = 1'b1; tick(); Rx_overrun_i = 1'b0; tick();
        end
        chk("t5.ovc", 32'(Overrun_count_o), 32'd5);
        check_all("t5");
        Rx_overrun_i = 1'b1;
        pulse_clear();
        Rx_overrun_i = 1'b0;
        tick();
        chk("t5.fec_clr", 32'(Frame_err_count_o), 32'h00);
        chk("t5.ovc_clr", 32'(Overrun_count_o), 32'h00);
        check_all("t5c");

        // Disabled: nothing captured, FIFO kept; re-enable captures
        send_byte(8'h66, cyc);
        Rx_enable_cfg_i = 1'b0;
        tick(); tick(); tick();
        u0 = unload_cnt;
        Rx_data_i = 8'h77; Rx_empty_i = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("t6.no_unload", 32'(unload_cnt), 32'(u0));
        chk("t6.kept", 32'(Level_o), 32'd1);
        Rx_enable_cfg_i = 1'b1;
        n = 0;
        while (!Rx_empty_i && n < 12) begin tick(); n++; end
        chk("t6.resume", 32'(Rx_empty_i), 32'd1);
        check_all("t6");
        pop_byte("t6.pop0", 8'h66);
        pop_byte("t6.pop1", 8'h77);

        // Randomized traffic against the model
        Threshold_i = LVL_W'($urandom_range(0, 16));
        for (int i = 0; i < 400; i++) begin
            rd_if.Rd_ready   = 1'($urandom_range(0, 2) == 0);
            Rx_overrun_i     = 1'($urandom_range(0, 5) == 0);
            Rx_frame_error_i = 1'($urandom_range(0, 5) == 0);
            Flush_i          = 1'($urandom_range(0, 60) == 0);
            Clear_status_i   = 1'($urandom_range(0, 70) == 0);
            if (Rx_empty_i && $urandom_range(0, 2) == 0) begin
                Rx_data_i  = 8'($urandom);
                Rx_empty_i = 1'b0;
            end
            tick();
            check_all("rnd");
        end
        rd_if.Rd_ready = 1'b0; Rx_overrun_i = 1'b0; Rx_frame_error_i = 1'b0;
        Flush_i = 1'b0; Clear_status_i = 1'b0; Threshold_i = '0;
        n = 0;
        while (!Rx_empty_i && n < 12) begin tick(); n++; end
        tick(); tick(); tick();
        check_all("rnd_end");

`ifdef UART_RX_SEQ_TIMEOUT_EN
        // Character timeout after an idle buffered byte
        pulse_flush();
        pulse_clear();
        send_byte(8'h99, cyc);
        n = 0;
        while (Timeout_o !== 1'b1 && n < 150) begin tick(); n++; end
        chk("t7.tmo", 32'(Timeout_o), 32'd1);
        chk("t7.window", 32'(n >= 95 && n <= 105), 32'd1);
        check_all("t7");
        pop_byte("t7.pop", 8'h99);
        for (int i = 0; i < 150; i++) tick();
        chk("t7.no_tmo", 32'(Timeout_o), 32'd0);
        check_all("t7e");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_sequencer.md
Name: uart_rx_sequencer

Overview:
Sequences the UART receive controller: enables it, detects each completed byte (Empty low), captures RX_data, pulses Unload_data and pushes the byte into a local FIFO. Presents a valid/ready byte stream to the AXI-lite register front end. Keeps saturating error counters and raises a level/overflow interrupt.

Parameters:
FIFO_DEPTH, 16, FIFO entries; power of two, range 2..256.
LVL_W, $clog2(FIFO_DEPTH)+1, width of level and threshold (derived, not overridable).
TIMEOUT_CYCLES, 16'd40000, idle clk cycles before a character timeout (optional feature only).

Ports:
clk  in  1  clock
Resetn  in  1  asynchronous, active-low reset
Rx_enable_cfg_i  in  1  software receive enable
Rx_enable_o  out  1  Enable to receive controller
Rx_data_i  in  8  RX_data from receive controller
Rx_empty_i  in  1  Empty from receive controller
Rx_overrun_i  in  1  Overrun from receive controller
Rx_frame_error_i  in  1  Frame_error from receive controller
Unload_data_o  out  1  Unload_data to receive controller
Rd_valid_o  out  1  FIFO head valid
Rd_data_o  out  8  FIFO head byte
Rd_ready_i  in  1  consumer pops when valid&ready
Flush_i  in  1  discard FIFO contents
Clear_status_i  in  1  clear counters and sticky flag
Threshold_i  in  LVL_W  interrupt level threshold, 0 = disabled
Level_o  out  LVL_W  current FIFO occupancy
Overrun_count_o  out  8  saturating overrun event count
Frame_err_count_o  out  8  saturating frame-error event count
Fifo_overflow_o  out  1  sticky: byte dropped because FIFO full
Timeout_o  out  1  character timeout flag
Irq_o  out  1  interrupt

Behaviour:
- Reset: all outputs 0; FSM S_RXS_IDLE; FIFO empty; edge-detect registers 0.
- Rx_enable_o = Rx_enable_cfg_i registered (1-cycle delay).
- FSM (Unload_data_o is high only in S_RXS_CAPTURE):
  S_RXS_IDLE: go to S_RXS_WAIT when Rx_enable_o = 1.
  S_RXS_WAIT: if Rx_enable_o = 0, go to IDLE. Else if Rx_empty_i = 0, go to S_RXS_CAPTURE.
  S_RXS_CAPTURE (1 cycle): assert Unload_data_o and push Rx_data_i. Always go to S_RXS_SETTLE, even if the enable drops.
  S_RXS_SETTLE (1 cycle): lets Empty return high; go to S_RXS_WAIT. If Empty is still low here, a new byte landed; WAIT captures it next cycle.
- Each received byte is pushed exactly once; minimum 3 cycles per byte.
- FIFO push/pop:
  Pop when Rd_valid_o & Rd_ready_i. Rd_data_o is the head byte (first-word fall-through); Rd_valid_o = Level_o != 0.
  Push into a full FIFO in the same cycle as a pop: accepted.
  Push into a full FIFO with no pop: byte dropped, Fifo_overflow_o set; the receiver is still unloaded.
  Pointers wrap modulo FIFO_DEPTH; Level_o ranges 0..FIFO_DEPTH.
- Flush_i: next cycle Level_o = 0. A push or pop in the same cycle is discarded. Counters and FSM are unaffected.
- Counters: increment on the rising edge of Rx_overrun_i / Rx_frame_error_i (input registered once for edge detect). Saturate at 8'hFF.
- Clear_status_i: zeroes both counters, Fifo_overflow_o and Timeout_o. If an edge arrives in the same cycle, clear wins.
- Irq_o (registered) = (Threshold_i != 0 && Level_o >= Threshold_i) | Fifo_overflow_o | Timeout_o.
- Rx_enable_cfg_i low mid-byte: FSM returns to IDLE after the current CAPTURE/SETTLE; FIFO contents are kept.

Optional Feature:
- Macro: UART_RX_SEQ_TIMEOUT_EN.
- Enabled: a 16-bit counter resets on every push, pop or flush. It increments while Level_o != 0. At TIMEOUT_CYCLES-1 it sets Timeout_o (sticky until Clear_status_i or FIFO empty) and holds.
- Disabled: counter is absent and Timeout_o is tied 0.

Decomposition:
- Package uart_pkg holds:
  - enum RX_Sequencer_state_type {S_RXS_IDLE, S_RXS_WAIT, S_RXS_CAPTURE, S_RXS_SETTLE};
  - counter-width constant (8);
  - default TIMEOUT_CYCLES.
- Sub-module uart_rx_fifo: synchronous FIFO with push/pop/flush/level ports, parameter FIFO_DEPTH.

Test Plan:
- Enable, feed 0x55 with Empty low for one capture → one Unload_data_o pulse 2 cycles later; Rd_data_o = 0x55 and Level_o = 1.
- Push 16 bytes 0x00..0x0F, then a 17th byte 0xAA with Rd_ready_i = 0 → 0xAA dropped, Fifo_overflow_o = 1, Irq_o = 1; pops return 0x00..0x0F in order.
- FIFO full, 0xBB arrives the same cycle as a pop → Level_o stays 16 and 0xBB is the last byte read.
- Threshold_i = 4 with 3 bytes buffered → Irq_o = 0; 4th byte → Irq_o = 1 one cycle after Level_o = 4; one pop → Irq_o = 0.
- Pulse Rx_frame_error_i 300 times → Frame_err_count_o = 0xFF; Clear_status_i → 0x00.
- Macro set, TIMEOUT_CYCLES = 100, one byte buffered and idle → Timeout_o high after 100 cycles; pop → counter resets and no further timeout.
